// File: rtl/led_arb_pkg.sv
// Shared types and constants for the LED bank arbiter and its round-robin picker.
package led_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int CLOCK_HZ = 100_000_000;
    // 100 ms slice keeps each pattern on the LEDs long enough to be read by eye
    localparam int SLICE_DEFAULT = CLOCK_HZ / 10;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr (wrapping),
// skipping any index set in the exclude mask.
module rr_picker #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic [N-1:0]  excl,
    output logic          valid,
    output logic [PW-1:0] idx
);

    logic [N-1:0] w_cand;

    assign w_cand = req & ~excl;

    // Scan from the farthest offset down so the closest candidate to ptr wins
    always_comb begin
        int j;
        j     = 0;
        valid = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (w_cand[j[PW-1:0]]) begin
                valid = 1'b1;
                idx   = j[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/led_arbiter.sv
// Time-sliced round-robin owner of the LED bank; each grant lasts at least SLICE
// clocks unless the owner drops its request, and every output is registered.
module led_arbiter
    import led_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int SLICE = SLICE_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] data,
    output logic [N-1:0]   grant,
    output logic [W-1:0]   led,
    output logic           busy,
    output logic           slice_end
);

    localparam int PW = $clog2(N);
    localparam int CW = $clog2(SLICE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SLICE - 1);
    localparam logic [PW-1:0] IDX_LAST = PW'(N - 1);
    localparam logic [N-1:0]  ONE_HOT0 = N'(1);

    state_t          r_state;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_owner;
    logic [CW-1:0]   r_cnt;
    logic [N-1:0]    r_grant;
    logic [W-1:0]    r_led;
    logic            r_slice_end;

    state_t          w_state_n;
    logic [PW-1:0]   w_ptr_n;
    logic [PW-1:0]   w_owner_n;
    logic [CW-1:0]   w_cnt_n;
    logic [N-1:0]    w_grant_n;
    logic            w_slice_end_n;
    logic            w_take;
    logic            w_valid;
    logic [PW-1:0]   w_pick;
    logic            w_owner_req;
    logic            w_expire;

    // r_grant is zero while idle, so it doubles as the "exclude current owner" mask
    rr_picker #(
        .N  (N),
        .PW (PW)
    ) u_picker (
        .req   (req),
        .ptr   (r_ptr),
        .excl  (r_grant),
        .valid (w_valid),
        .idx   (w_pick)
    );

    assign w_owner_req = req[r_owner];
    assign w_expire    = (r_cnt == CNT_LAST);

    always_comb begin
        w_state_n     = r_state;
        w_ptr_n       = r_ptr;
        w_owner_n     = r_owner;
        w_cnt_n       = r_cnt;
        w_grant_n     = r_grant;
        w_slice_end_n = 1'b0;
        w_take        = 1'b0;
        case (r_state)
            IDLE: begin
                w_take = w_valid;
            end
            GRANT: begin
                // Owner drop is checked before slice renewal so a dropped owner is never renewed
                if (!w_owner_req || w_expire) begin
                    if (w_valid) begin
                        w_take = 1'b1;
                    end else if (!w_owner_req) begin
                        w_state_n = IDLE;
                        w_grant_n = '0;
                        w_cnt_n   = '0;
                    end else begin
                        w_cnt_n       = '0;
                        w_slice_end_n = 1'b1;
                    end
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_n = IDLE;
                w_grant_n = '0;
            end
        endcase
        if (w_take) begin
            w_state_n = GRANT;
            w_owner_n = w_pick;
            w_grant_n = ONE_HOT0 << w_pick;
            w_cnt_n   = '0;
            w_ptr_n   = (w_pick == IDX_LAST) ? '0 : w_pick + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_cnt       <= '0;
            r_grant     <= '0;
            r_led       <= '0;
            r_slice_end <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_ptr       <= w_ptr_n;
            r_owner     <= w_owner_n;
            r_cnt       <= w_cnt_n;
            r_grant     <= w_grant_n;
            r_slice_end <= w_slice_end_n;
            r_led       <= (w_state_n == GRANT) ? data[int'(w_owner_n)*W +: W] : '0;
        end
    end

    assign grant     = r_grant;
    assign led       = r_led;
    assign busy      = (r_state == GRANT);
    assign slice_end = r_slice_end;

endmodule

// File: tb/tb_led_arbiter.sv
// Bench for led_arbiter (N=4, W=8, SLICE=4): per-cycle behavioural model plus
// directed scenarios with literal expectations.
module tb_led_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int SLICE = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic [N-1:0]   grant;
    logic [W-1:0]   led;
    logic           busy;
    logic           slice_end;

    int checks = 0;
    int errors = 0;

    led_arbiter #(
        .N     (N),
        .W     (W),
        .SLICE (SLICE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .data      (data),
        .grant     (grant),
        .led       (led),
        .busy      (busy),
        .slice_end (slice_end)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // First requester at or after p (wrapping), ignoring index ex; -1 if none
    function automatic int pick(input logic [N-1:0] r, input int p, input int ex);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (p + k) % N;
            if (r[j] && j != ex) return j;
        end
        return -1;
    endfunction

    // Model: who owns the LEDs, for how many cycles so far in this slice
    int          m_owner = -1;
    int          m_ptr   = 0;
    int          m_held  = 0;
    logic        m_se    = 1'b0;
    logic [N-1:0] exp_grant;
    logic [W-1:0] exp_led;

    always @(posedge clk) begin
        logic [N-1:0]   r;
        logic [N*W-1:0] d;
        int             nxt;
        r = req;
        d = data;
        if (reset) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
            m_se    = 1'b0;
        end else begin
            m_se = 1'b0;
            if (m_owner < 0) begin
                nxt = pick(r, m_ptr, -1);
                if (nxt >= 0) begin
                    m_owner = nxt;
                    m_held  = 1;
                    m_ptr   = (nxt + 1) % N;
                end
            end else if (!r[m_owner] || m_held == SLICE) begin
                nxt = pick(r, m_ptr, m_owner);
                if (nxt >= 0) begin
                    m_owner = nxt;
                    m_held  = 1;
                    m_ptr   = (nxt + 1) % N;
                end else if (!r[m_owner]) begin
                    m_owner = -1;
                    m_held  = 0;
                end else begin
                    m_held = 1;
                    m_se   = 1'b1;
                end
            end else begin
                m_held++;
            end
        end
        exp_grant = (m_owner < 0) ? '0 : (N'(1) << m_owner);
        exp_led   = (m_owner < 0) ? '0 : d[m_owner*W +: W];
        #1;
        check("m_grant", 32'(grant), 32'(exp_grant));
        check("m_led", 32'(led), 32'(exp_led));
        check("m_busy", 32'(busy), 32'(m_owner >= 0));
        check("m_slice_end", 32'(slice_end), 32'(m_se));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int se_cnt;
        int mism;
        logic [W-1:0] want;

        reset = 1'b1;
        req   = 4'b1111;
        data  = 32'h88_44_22_A5;

        // Reset held two cycles with all requests high
        tick();
        check("t1_rst_grant_a", 32'(grant), 32'h0);
        check("t1_rst_led_a", 32'(led), 32'h0);
        check("t1_rst_busy_a", 32'(busy), 32'h0);
        tick();
        check("t1_rst_grant_b", 32'(grant), 32'h0);
        check("t1_rst_busy_b", 32'(busy), 32'h0);
        reset = 1'b0;
        tick();
        check("t1_first_grant", 32'(grant), 32'h1);
        check("t1_first_led", 32'(led), 32'hA5);

        // Single requester keeps the LEDs and renews every SLICE cycles
        do_reset();
        data = 32'h00_00_00_A5;
        req  = 4'b0001;
        tick();
        check("t2_grant", 32'(grant), 32'h1);
        check("t2_led", 32'(led), 32'hA5);
        se_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (slice_end === 1'b1) se_cnt++;
        end
        check("t2_pulses", 32'(se_cnt), 32'd3);
        check("t2_grant_held", 32'(grant), 32'h1);

        // Two contenders alternate in 4-cycle blocks
        do_reset();
        data = 32'h00_44_00_11;
        req  = 4'b0101;
        mism = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            want = (((i / 4) % 2) == 0) ? 8'h11 : 8'h44;
            if (led !== want) mism++;
            if (i == 4) check("t3_grant_b", 32'(grant), 32'h4);
            if (i == 8) check("t3_grant_a", 32'(grant), 32'h1);
        end
        check("t3_alt_mismatches", 32'(mism), 32'd0);

        // Owner drops with another request pending: direct hand-off
        do_reset();
        data = 32'h88_44_22_11;
        req  = 4'b0010;
        tick();
        check("t4_grant1", 32'(grant), 32'h2);
        tick();
        req = 4'b1000;
        tick();
        check("t4_handoff", 32'(grant), 32'h8);
        check("t4_handoff_led", 32'(led), 32'h88);
        check("t4_handoff_busy", 32'(busy), 32'h1);

        // Owner drops with nothing pending: idle next cycle
        do_reset();
        req = 4'b0010;
        tick();
        tick();
        req = 4'b0000;
        tick();
        check("t4_idle_grant", 32'(grant), 32'h0);
        check("t4_idle_led", 32'(led), 32'h0);
        check("t4_idle_busy", 32'(busy), 32'h0);

        // Wrap-around: after req3 the pointer is back at 0
        do_reset();
        req = 4'b1000;
        tick();
        check("t5_grant3", 32'(grant), 32'h8);
        req = 4'b1001;
        repeat (3) tick();
        check("t5_still3", 32'(grant), 32'h8);
        tick();
        check("t5_wrap0", 32'(grant), 32'h1);
        check("t5_wrap0_led", 32'(led), 32'h11);
        repeat (4) tick();
        check("t5_back3", 32'(grant), 32'h8);

        // Reset mid-slice clears everything, then pointer restarts at 0
        do_reset();
        req = 4'b0001;
        tick();
        check("t6_grant0", 32'(grant), 32'h1);
        tick();
        reset = 1'b1;
        tick();
        check("t6_rst_grant", 32'(grant), 32'h0);
        check("t6_rst_led", 32'(led), 32'h0);
        check("t6_rst_busy", 32'(busy), 32'h0);
        check("t6_rst_se", 32'(slice_end), 32'h0);
        reset = 1'b0;
        req   = 4'b0110;
        tick();
        check("t6_rereq", 32'(grant), 32'h2);
        check("t6_rereq_led", 32'(led), 32'h22);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
